// File: rtl/mult_pkg.sv
// Shared definitions for the multiple-of-3 / even sequence generator:
// class-select encodings, the generator state enum and the value width.
package mult_pkg;

   localparam int WIDTH = 4;

   typedef enum logic [1:0] {
      MODE_M3   = 2'b00,
      MODE_EVEN = 2'b01,
      MODE_ANY  = 2'b10,
      MODE_BOTH = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SEARCH = 2'b01,
      OFFER  = 2'b10,
      WAIT   = 2'b11
   } state_t;

endpackage

// File: rtl/mult_pred.sv
// Combinational class predicate for a 4-bit candidate. Zero belongs to no
// class, matching the LED classifier truth table.
module mult_pred (
   input  logic [3:0] cand,
   input  logic [1:0] mode,
   output logic       match
);
   import mult_pkg::*;

   logic m3_s;
   logic even_s;

   // Decode the two base classes and combine them according to mode.
   always_comb begin
      m3_s   = 1'b0;
      even_s = 1'b0;
      match  = 1'b0;
      case (cand)
         4'd3, 4'd6, 4'd9, 4'd12, 4'd15: m3_s = 1'b1;
         default:                        m3_s = 1'b0;
      endcase
      if ((cand != 4'd0) && (cand[0] == 1'b0)) begin
         even_s = 1'b1;
      end else begin
         even_s = 1'b0;
      end
      case (mode)
         MODE_M3:   match = m3_s;
         MODE_EVEN: match = even_s;
         MODE_ANY:  match = m3_s | even_s;
         MODE_BOTH: match = m3_s & even_s;
         default:   match = 1'b0;
      endcase
   end

endmodule

// File: rtl/mult_seq_gen.sv
// Paced source of 4-bit class members: walks candidates upward, offers each
// member on a valid/ready handshake, then idles DIV clocks before resuming.
module mult_seq_gen #(
   parameter int WIDTH = mult_pkg::WIDTH,
   parameter int DIV   = 100_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic             out_ready,
   output logic [WIDTH-1:0] value,
   output logic             out_valid,
   output logic             busy,
   output logic             wrapped
);
   import mult_pkg::*;

   localparam int               PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRES_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0]    PRES_ONE  = PW'(1);
   localparam logic [WIDTH-1:0] CAND_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] CAND_MAX  = {WIDTH{1'b1}};

   state_t           state_r;
   logic [WIDTH-1:0] cand_r;
   logic [PW-1:0]    pres_r;
   mode_t            mode_q_r;
   logic             match_s;

   mult_pred u_pred (
      .cand  (cand_r[3:0]),
      .mode  (mode_q_r),
      .match (match_s)
   );

   // Generator FSM; every output is a register so out_ready never reaches out_valid combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cand_r    <= {WIDTH{1'b0}};
         pres_r    <= {PW{1'b0}};
         mode_q_r  <= MODE_M3;
         value     <= {WIDTH{1'b0}};
         out_valid <= 1'b0;
         busy      <= 1'b0;
         wrapped   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               wrapped   <= 1'b0;
               out_valid <= 1'b0;
               if (start && !stop) begin
                  mode_q_r <= mode_t'(mode);
                  cand_r   <= {WIDTH{1'b0}};
                  state_r  <= SEARCH;
                  busy     <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            SEARCH: begin
               if (stop) begin
                  state_r   <= IDLE;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  wrapped   <= 1'b0;
               end else if (match_s) begin
                  value     <= cand_r;
                  out_valid <= 1'b1;
                  state_r   <= OFFER;
                  wrapped   <= 1'b0;
               end else begin
                  cand_r  <= cand_r + CAND_ONE;
                  wrapped <= (cand_r == CAND_MAX);
               end
            end
            OFFER: begin
               wrapped <= 1'b0;
               if (out_ready) begin
                  // A transfer on the same edge as stop still completes.
                  out_valid <= 1'b0;
                  pres_r    <= {PW{1'b0}};
                  state_r   <= stop ? IDLE : WAIT;
                  busy      <= !stop;
               end else if (stop) begin
                  out_valid <= 1'b0;
                  state_r   <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            WAIT: begin
               if (stop) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  wrapped <= 1'b0;
               end else if (pres_r == PRES_LAST) begin
                  cand_r  <= value + CAND_ONE;
                  wrapped <= (value == CAND_MAX);
                  state_r <= SEARCH;
               end else begin
                  pres_r  <= pres_r + PRES_ONE;
                  wrapped <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
               wrapped   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_gen.sv
// Scoreboard bench for mult_seq_gen: stimulus pushes hand-computed values,
// a negedge monitor pops and compares on every handshake transfer.
module tb_mult_seq_gen;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [1:0] mode;
   logic       out_ready;
   logic [3:0] value;
   logic       out_valid;
   logic       busy;
   logic       wrapped;

   int         n_cmp    = 0;
   int         n_err    = 0;
   int         xfer_cnt = 0;
   int         wrap_cnt = 0;
   logic [3:0] exp_q[$];

   mult_seq_gen #(.WIDTH(4), .DIV(DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .out_ready (out_ready),
      .value     (value),
      .out_valid (out_valid),
      .busy      (busy),
      .wrapped   (wrapped)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_xfers(input int target, input string name);
      int k;
      k = 0;
      while (xfer_cnt < target && k < 400) begin
         tick(1);
         k++;
      end
      check({name, "_xfers"}, xfer_cnt, target);
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         tick(1);
         k++;
      end
      check({name, "_valid"}, out_valid, 1);
   endtask

   task automatic start_run(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic stop_run();
      out_ready = 1'b0;
      stop      = 1'b1;
      tick(1);
      stop = 1'b0;
      check("stop_busy", busy, 0);
   endtask

   // Monitor: pops the scoreboard on each transfer and checks inter-offer spacing.
   initial begin : monitor
      logic [3:0] prev_val;
      logic [3:0] gap;
      logic       have_prev;
      logic       prev_valid;
      int         cyc;
      int         xfer_cyc;
      prev_val   = 4'd0;
      have_prev  = 1'b0;
      prev_valid = 1'b0;
      cyc        = 0;
      xfer_cyc   = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (wrapped) wrap_cnt++;
         if (!busy) have_prev = 1'b0;
         if (out_valid && !prev_valid && have_prev) begin
            gap = value - prev_val;
            check("offer_spacing", cyc - xfer_cyc, DIV + int'(gap) + 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL xfer_unexpected: got value %0d, expected no transfer", value);
            end else begin
               check("xfer_value", value, exp_q.pop_front());
            end
            xfer_cnt++;
            prev_val  = value;
            have_prev = 1'b1;
            xfer_cyc  = cyc;
         end
         prev_valid = out_valid;
      end
   end

   // Directed stimulus.
   initial begin : stimulus
      int   base;
      int   w0;
      int   k;
      logic stable;
      logic [3:0] even_v[8]  = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd2};
      logic [3:0] any_v[11]  = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd14, 4'd15, 4'd2};
      logic [3:0] m3_v[6]    = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd3};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0; mode = 2'b00;
      tick(2);
      check("rst_value", value, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_wrapped", wrapped, 0);
      rst_n = 1'b1;
      tick(1);

      // Mode 00 with a mid-run mode change that must be ignored.
      out_ready = 1'b1; base = xfer_cnt; w0 = wrap_cnt;
      foreach (m3_v[i]) exp_q.push_back(m3_v[i]);
      start_run(2'b00);
      mode = 2'b01;
      wait_xfers(base + 6, "m3");
      stop_run();
      check("m3_wraps", wrap_cnt - w0, 1);

      // Mode 01: start-to-valid latency, then the full even sequence.
      out_ready = 1'b1; base = xfer_cnt; w0 = wrap_cnt;
      foreach (even_v[i]) exp_q.push_back(even_v[i]);
      mode = 2'b01; start = 1'b1;
      tick(1);
      k = 1;
      start = 1'b0;
      while (!out_valid && k < 20) begin
         tick(1);
         k++;
      end
      check("latency_edges", k, 4);
      check("latency_value", value, 2);
      wait_xfers(base + 8, "even");
      stop_run();
      check("even_wraps", wrap_cnt - w0, 1);

      // Mode 11.
      out_ready = 1'b1; base = xfer_cnt;
      exp_q.push_back(4'd6); exp_q.push_back(4'd12); exp_q.push_back(4'd6);
      start_run(2'b11);
      wait_xfers(base + 3, "both");
      stop_run();

      // Mode 10 with a mid-run mode change.
      out_ready = 1'b1; base = xfer_cnt; w0 = wrap_cnt;
      foreach (any_v[i]) exp_q.push_back(any_v[i]);
      start_run(2'b10);
      mode = 2'b00;
      wait_xfers(base + 11, "any");
      stop_run();
      check("any_wraps", wrap_cnt - w0, 1);

      // Backpressure on value 6, then stop while offering 12.
      out_ready = 1'b1; base = xfer_cnt;
      exp_q.push_back(4'd3); exp_q.push_back(4'd6); exp_q.push_back(4'd9);
      start_run(2'b00);
      wait_xfers(base + 1, "bp_first");
      out_ready = 1'b0;
      wait_valid("bp");
      check("bp_value", value, 6);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (value != 4'd6 || !out_valid) stable = 1'b0;
      end
      check("bp_hold", stable, 1);
      out_ready = 1'b1;
      wait_xfers(base + 3, "bp_release");
      out_ready = 1'b0;
      wait_valid("offer12");
      check("offer12_value", value, 12);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      check("stop_offer_valid", out_valid, 0);
      check("stop_offer_busy", busy, 0);
      check("stop_offer_value", value, 12);

      // start and stop together from IDLE.
      start = 1'b1; stop = 1'b1;
      tick(3);
      check("startstop_busy", busy, 0);
      check("startstop_valid", out_valid, 0);
      start = 1'b0; stop = 1'b0;
      tick(1);

      // Asynchronous reset mid-SEARCH.
      out_ready = 1'b0;
      start_run(2'b00);
      tick(1);
      check("pre_rst1_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst1_value", value, 0);
      check("rst1_valid", out_valid, 0);
      check("rst1_busy", busy, 0);
      check("rst1_wrapped", wrapped, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick(1);

      // Asynchronous reset mid-WAIT.
      out_ready = 1'b1; base = xfer_cnt;
      exp_q.push_back(4'd3); exp_q.push_back(4'd6);
      start_run(2'b00);
      wait_xfers(base + 2, "pre_rst2");
      tick(2);
      check("pre_rst2_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst2_value", value, 0);
      check("rst2_busy", busy, 0);
      check("rst2_valid", out_valid, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      tick(1);

      // Restart after reset yields the first member again.
      out_ready = 1'b1; base = xfer_cnt;
      exp_q.push_back(4'd3);
      start_run(2'b00);
      wait_xfers(base + 1, "restart");
      stop_run();

      tick(2);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
